// File: rtl/lockstep_checker.sv
// Multi-channel lockstep comparator: buffers an expected trace in a FIFO and checks per-cycle observed taps.
// Optional per-channel mismatch counters are enabled by defining LOCKSTEP_CHECKER_CHAN_CNT_EN.
module lockstep_checker #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         total_vectors,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [CHANNELS*XLEN-1:0] exp_data,
  input  logic [CHANNELS*XLEN-1:0] exp_mask,
  input  logic                     obs_valid,
  input  logic [CHANNELS*XLEN-1:0] obs_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         vector_num,
  output logic [CNT_W-1:0]         error_count,
  output logic                     underrun,
  output logic [CNT_W-1:0]         first_err_vector,
  output logic [2:0]               first_err_channel,
  output logic [XLEN-1:0]          first_err_observed,
  output logic [XLEN-1:0]          first_err_expected
`ifdef LOCKSTEP_CHECKER_CHAN_CNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] chan_err_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = CHANNELS * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [W-1:0]        mem_data [DEPTH];
  logic [W-1:0]        mem_mask [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    total_q;

  logic                empty, full, push, pop, sample, accept_start;
  logic [W-1:0]        head_data, head_mask;
  logic [CHANNELS-1:0] mis;
  logic                any_mis, vec_err;
  logic [2:0]          err_ch;
  logic [XLEN-1:0]     err_obs, err_exp;
  logic [CNT_W-1:0]    next_vec;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign exp_ready    = busy && !full;
  assign push         = exp_valid && exp_ready;
  assign sample       = obs_valid && (state == RUN);
  assign pop          = sample && !empty;
  assign accept_start = start && (state != RUN);
  assign next_vec     = vector_num + 1'b1;
  assign vec_err      = empty || any_mis;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= exp_data;
      mem_mask[wr_ptr[AW-1:0]] <= exp_mask;
    end
  end

  // Lowest mismatching channel wins; an empty FIFO reports channel 0 with a zero expected value.
  always_comb begin
    head_data = mem_data[rd_ptr[AW-1:0]];
    head_mask = mem_mask[rd_ptr[AW-1:0]];
    mis       = '0;
    any_mis   = 1'b0;
    err_ch    = '0;
    err_obs   = '0;
    err_exp   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      mis[c] = |((obs_data[c*XLEN +: XLEN] ^ head_data[c*XLEN +: XLEN]) & ~head_mask[c*XLEN +: XLEN]);
      if (mis[c] && !any_mis) begin
        any_mis = 1'b1;
        err_ch  = 3'(c);
        err_obs = obs_data[c*XLEN +: XLEN];
        err_exp = head_data[c*XLEN +: XLEN];
      end
    end
    if (empty) begin
      any_mis = 1'b0;
      err_ch  = '0;
      err_obs = obs_data[XLEN-1:0];
      err_exp = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      total_q            <= '0;
      vector_num         <= '0;
      error_count        <= '0;
      underrun           <= 1'b0;
      first_err_vector   <= '0;
      first_err_channel  <= '0;
      first_err_observed <= '0;
      first_err_expected <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            total_q            <= total_vectors;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            vector_num         <= '0;
            error_count        <= '0;
            underrun           <= 1'b0;
            first_err_vector   <= '0;
            first_err_channel  <= '0;
            first_err_observed <= '0;
            first_err_expected <= '0;
            if (total_vectors == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          if (sample) begin
            vector_num <= next_vec;
            if (empty) underrun <= 1'b1;
            if (vec_err) begin
              if (error_count != '1) error_count <= error_count + 1'b1;
              if (error_count == '0) begin
                first_err_vector   <= vector_num;
                first_err_channel  <= err_ch;
                first_err_observed <= err_obs;
                first_err_expected <= err_exp;
              end
            end
            if (next_vec == total_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (error_count == '0) && !vec_err;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCKSTEP_CHECKER_CHAN_CNT_EN
  logic [CNT_W-1:0] chan_cnt [CHANNELS];

  // Underrun vectors have no valid head entry, so they never count against a channel.
  always_ff @(posedge clk) begin
    if (!reset || accept_start) begin
      for (int unsigned c = 0; c < CHANNELS; c++) chan_cnt[c] <= '0;
    end else if (pop) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (mis[c] && (chan_cnt[c] != '1)) chan_cnt[c] <= chan_cnt[c] + 1'b1;
      end
    end
  end

  always_comb begin
    chan_err_count = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) chan_err_count[c*CNT_W +: CNT_W] = chan_cnt[c];
  end
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: table-driven compare runs plus underrun, full-FIFO and reset sequences.
module tb_lockstep_checker;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned CH    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset, start, exp_valid, obs_valid;
  logic [CNT_W-1:0]  total_vectors;
  logic              exp_ready, busy, done, pass, underrun;
  logic [CH*XLEN-1:0] exp_data, exp_mask, obs_data;
  logic [CNT_W-1:0]  vector_num, error_count, first_err_vector;
  logic [2:0]        first_err_channel;
  logic [XLEN-1:0]   first_err_observed, first_err_expected;
`ifdef LOCKSTEP_CHECKER_CHAN_CNT_EN
  logic [CH*CNT_W-1:0] chan_err_count;
`endif

  always #5 clk = ~clk;

  lockstep_checker #(.XLEN(XLEN), .CHANNELS(CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .total_vectors(total_vectors),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_mask(exp_mask),
    .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy), .done(done), .pass(pass),
    .vector_num(vector_num), .error_count(error_count), .underrun(underrun),
    .first_err_vector(first_err_vector), .first_err_channel(first_err_channel),
    .first_err_observed(first_err_observed), .first_err_expected(first_err_expected)
`ifdef LOCKSTEP_CHECKER_CHAN_CNT_EN
    , .chan_err_count(chan_err_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    total_vectors = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [63:0] d1, input logic [63:0] d0, input logic [63:0] m1);
    exp_data  = {d1, d0};
    exp_mask  = {m1, 64'h0};
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic strobe(input logic [63:0] o1, input logic [63:0] o0);
    obs_data  = {o1, o0};
    obs_valid = 1'b1;
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 128'(busy), 128'h0);
    check({tag, ".done"}, 128'(done), 128'h0);
    check({tag, ".pass"}, 128'(pass), 128'h0);
    check({tag, ".exp_ready"}, 128'(exp_ready), 128'h0);
    check({tag, ".vector_num"}, 128'(vector_num), 128'h0);
    check({tag, ".error_count"}, 128'(error_count), 128'h0);
    check({tag, ".underrun"}, 128'(underrun), 128'h0);
    check({tag, ".fvec"}, 128'(first_err_vector), 128'h0);
    check({tag, ".fch"}, 128'(first_err_channel), 128'h0);
    check({tag, ".fobs"}, 128'(first_err_observed), 128'h0);
    check({tag, ".fexp"}, 128'(first_err_expected), 128'h0);
  endtask

  typedef struct {
    logic [63:0] e1, e0, m1, o1, o0;
    logic [31:0] ec, fv;
    logic [2:0]  fch;
    logic [63:0] fo, fe;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] exp_c0 [4];
  logic [31:0] exp_c1 [4];

  initial begin
    // Run 0: four clean vectors
    tbl[0]  = '{64'h200, 64'h100, 64'h0, 64'h200, 64'h100, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[1]  = '{64'h201, 64'h101, 64'h0, 64'h201, 64'h101, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[2]  = '{64'h202, 64'h102, 64'h0, 64'h202, 64'h102, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[3]  = '{64'h203, 64'h103, 64'h0, 64'h203, 64'h103, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    // Run 1: vector 2 channel 1 mismatch, unmasked
    tbl[4]  = '{64'h201, 64'h101, 64'h0, 64'h201, 64'h101, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[5]  = '{64'h202, 64'h102, 64'h0, 64'h202, 64'h102, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[6]  = '{64'h11,  64'h103, 64'h0, 64'h10,  64'h103, 32'd1, 32'd2, 3'd1, 64'h10, 64'h11};
    tbl[7]  = '{64'h204, 64'h104, 64'h0, 64'h204, 64'h104, 32'd1, 32'd2, 3'd1, 64'h10, 64'h11};
    // Run 2: same vector 2 with bit 0 masked off
    tbl[8]  = '{64'h201, 64'h101, 64'h0, 64'h201, 64'h101, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[9]  = '{64'h202, 64'h102, 64'h0, 64'h202, 64'h102, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[10] = '{64'h11,  64'h103, 64'h1, 64'h10,  64'h103, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[11] = '{64'h204, 64'h104, 64'h0, 64'h204, 64'h104, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    // Run 3: both channels mismatch on vectors 1 and 3
    tbl[12] = '{64'h300, 64'h301, 64'h0, 64'h300, 64'h301, 32'd0, 32'd0, 3'd0, 64'h0, 64'h0};
    tbl[13] = '{64'h5,   64'hAAAA, 64'h0, 64'h7,  64'hAAAB, 32'd1, 32'd1, 3'd0, 64'hAAAB, 64'hAAAA};
    tbl[14] = '{64'h302, 64'h303, 64'h0, 64'h302, 64'h303, 32'd1, 32'd1, 3'd0, 64'hAAAB, 64'hAAAA};
    tbl[15] = '{64'hF0,  64'h1,   64'h0, 64'h0F,  64'h0,   32'd2, 32'd1, 3'd0, 64'hAAAB, 64'hAAAA};
    exp_c0 = '{32'd0, 32'd0, 32'd0, 32'd2};
    exp_c1 = '{32'd0, 32'd1, 32'd0, 32'd2};

    reset = 1'b0; start = 1'b0; exp_valid = 1'b0; obs_valid = 1'b0;
    total_vectors = '0; exp_data = '0; exp_mask = '0; obs_data = '0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    for (int r = 0; r < 4; r++) begin
      do_start(32'd4);
      check("run.busy", 128'(busy), 128'h1);
      check("run.exp_ready", 128'(exp_ready), 128'h1);
      for (int k = 0; k < 4; k++) push(tbl[r*4+k].e1, tbl[r*4+k].e0, tbl[r*4+k].m1);
      for (int k = 0; k < 4; k++) begin
        strobe(tbl[r*4+k].o1, tbl[r*4+k].o0);
        check("tbl.vector_num", 128'(vector_num), 128'(k + 1));
        check("tbl.error_count", 128'(error_count), 128'(tbl[r*4+k].ec));
        check("tbl.fvec", 128'(first_err_vector), 128'(tbl[r*4+k].fv));
        check("tbl.fch", 128'(first_err_channel), 128'(tbl[r*4+k].fch));
        check("tbl.fobs", 128'(first_err_observed), 128'(tbl[r*4+k].fo));
        check("tbl.fexp", 128'(first_err_expected), 128'(tbl[r*4+k].fe));
        check("tbl.done", 128'(done), 128'(k == 3));
      end
      check("run.pass", 128'(pass), 128'(tbl[r*4+3].ec == 0));
      check("run.busy_end", 128'(busy), 128'h0);
`ifdef LOCKSTEP_CHECKER_CHAN_CNT_EN
      check("run.chan0", 128'(chan_err_count[CNT_W-1:0]), 128'(exp_c0[r]));
      check("run.chan1", 128'(chan_err_count[2*CNT_W-1:CNT_W]), 128'(exp_c1[r]));
`endif
    end

    // obs_valid in DONE is ignored
    strobe(64'h1, 64'h2);
    check("done_ign.vector_num", 128'(vector_num), 128'h4);
    check("done_ign.error_count", 128'(error_count), 128'h2);

    // Underrun at vector 0
    do_start(32'd2);
    strobe(64'h0, 64'h33);
    check("under.flag", 128'(underrun), 128'h1);
    check("under.error_count", 128'(error_count), 128'h1);
    check("under.fvec", 128'(first_err_vector), 128'h0);
    check("under.fch", 128'(first_err_channel), 128'h0);
    check("under.fobs", 128'(first_err_observed), 128'h33);
    check("under.fexp", 128'(first_err_expected), 128'h0);
    push(64'h5, 64'h6, 64'h0);
    strobe(64'h5, 64'h6);
    check("under.done", 128'(done), 128'h1);
    check("under.pass", 128'(pass), 128'h0);
    check("under.vector_num", 128'(vector_num), 128'h2);
`ifdef LOCKSTEP_CHECKER_CHAN_CNT_EN
    check("under.chan0", 128'(chan_err_count[CNT_W-1:0]), 128'h0);
`endif

    // No bypass: push and strobe together on an empty FIFO
    do_start(32'd1);
    check("bypass.underrun_clr", 128'(underrun), 128'h0);
    exp_data = {64'h7, 64'h8}; exp_mask = '0; exp_valid = 1'b1;
    obs_data = {64'h7, 64'h8}; obs_valid = 1'b1;
    tick();
    exp_valid = 1'b0; obs_valid = 1'b0;
    check("bypass.underrun", 128'(underrun), 128'h1);
    check("bypass.error_count", 128'(error_count), 128'h1);
    check("bypass.done", 128'(done), 128'h1);
    check("bypass.pass", 128'(pass), 128'h0);

    // Full FIFO: push refused while a pop happens in the same cycle
    do_start(32'd20);
    for (int i = 0; i < 16; i++) begin
      check("full.ready_fill", 128'(exp_ready), 128'h1);
      push(64'h1000 + 64'(i), 64'h2000 + 64'(i), 64'h0);
    end
    check("full.ready_full", 128'(exp_ready), 128'h0);
    exp_data = {64'hDEAD, 64'hBEEF}; exp_mask = '0; exp_valid = 1'b1;
    obs_data = {64'h1000, 64'h2000}; obs_valid = 1'b1;
    tick();
    exp_valid = 1'b0; obs_valid = 1'b0;
    check("full.ready_15", 128'(exp_ready), 128'h1);
    check("full.error_count", 128'(error_count), 128'h0);
    check("full.vector_num", 128'(vector_num), 128'h1);
    total_vectors = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("full.start_ign_busy", 128'(busy), 128'h1);
    check("full.start_ign_vec", 128'(vector_num), 128'h1);
    push(64'h1010, 64'h2010, 64'h0);
    check("full.ready_refull", 128'(exp_ready), 128'h0);
    for (int i = 1; i < 5; i++) strobe(64'h1000 + 64'(i), 64'h2000 + 64'(i));
    check("full.vec5", 128'(vector_num), 128'h5);
    check("full.ec5", 128'(error_count), 128'h0);

    // Reset mid-run aborts, then a zero-length run completes at once
    reset = 1'b0;
    tick();
    check_all_zero("abort");
    reset = 1'b1;
    do_start(32'd0);
    check("zero.done", 128'(done), 128'h1);
    check("zero.pass", 128'(pass), 128'h1);
    check("zero.busy", 128'(busy), 128'h0);
    do_start(32'd1);
    strobe(64'h1001, 64'h2001);
    check("flush.underrun", 128'(underrun), 128'h1);
    check("flush.done", 128'(done), 128'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
